// File: rtl/spi_dac_pkg.sv
// Shared types and helpers for the SPI-fed multi-channel DAC receiver.
package spi_dac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } spi_state_e;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int frame_w(input int ch_w, input int d_w);
        return ch_w + d_w;
    endfunction

endpackage

// File: rtl/spi_bit_sync.sv
// Single-bit multi-flop synchroniser with a configurable reset level.
module spi_bit_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= {STAGES{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/spi_dac_rx.sv
// Oversampling SPI slave that writes {channel, code} frames into shadow
// registers and transfers them to the active DAC codes.
module spi_dac_rx
    import spi_dac_pkg::*;
#(
    parameter int D_W         = 8,
    parameter int N_CH        = 4,
    parameter int CH_W        = 2,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int AUTO_LOAD   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    input  logic                  ldac,
    output logic [N_CH*D_W-1:0]   dac_data,
    output logic                  frame_valid,
    output logic [CH_W-1:0]       frame_ch,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int FRAME_W = frame_w(CH_W, D_W);
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int WARM_W  = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_OVER  = CNT_W'(FRAME_W + 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);
    localparam logic [1:0] MODE        = {1'(CPOL), 1'(CPHA)};
    localparam logic       SAMPLE_RISE = (MODE == SPI_MODE0) || (MODE == SPI_MODE3);

    logic sclk_sync, cs_sync, mosi_sync;
    logic sclk_prev_reg, cs_prev_reg;

    spi_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL != 0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_sync));
    spi_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs_n), .q(cs_sync));
    spi_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_sync));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev_reg <= (CPOL != 0);
            cs_prev_reg   <= 1'b1;
        end else begin
            sclk_prev_reg <= sclk_sync;
            cs_prev_reg   <= cs_sync;
        end
    end

    spi_state_e        state_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [FRAME_W-1:0] shift_reg;
    logic [WARM_W-1:0] warm_reg;
    logic              busy_reg, commit_pend_reg, err_pend_reg;
    logic              frame_valid_reg, frame_err_reg;
    logic [CH_W-1:0]   frame_ch_reg;

    logic              warm, sample_edge, cs_fall, cs_rise, ch_ok;
    logic [CH_W-1:0]   addr;
    logic [D_W-1:0]    data;
    logic [2**CH_W-1:0] ch_ok_vec;

    // The reset values of the chains only flush out after a few cycles; a cs_n
    // fall seen before then is an artefact of reset, not a real frame start.
    assign warm        = (warm_reg == WARM_DONE);
    assign sample_edge = SAMPLE_RISE ? (sclk_sync & ~sclk_prev_reg)
                                     : (~sclk_sync & sclk_prev_reg);
    assign cs_fall     = ~cs_sync & cs_prev_reg & warm;
    assign cs_rise     = cs_sync & ~cs_prev_reg;
    assign addr        = shift_reg[FRAME_W-1 -: CH_W];
    assign data        = shift_reg[D_W-1:0];
    assign ch_ok       = ch_ok_vec[addr];

    for (genvar gi = 0; gi < 2**CH_W; gi++) begin : g_ch_ok
        assign ch_ok_vec[gi] = (gi < N_CH) ? 1'b1 : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            warm_reg        <= '0;
            busy_reg        <= 1'b0;
            commit_pend_reg <= 1'b0;
            err_pend_reg    <= 1'b0;
        end else begin
            commit_pend_reg <= 1'b0;
            err_pend_reg    <= 1'b0;
            if (!warm) warm_reg <= warm_reg + WARM_W'(1);
            case (state_reg)
                IDLE: begin
                    if (cs_fall) begin
                        state_reg   <= SHIFT;
                        bit_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                    end else if (warm && !cs_sync) begin
                        state_reg <= WAIT_CS;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        if (bit_cnt_reg == CNT_FULL && ch_ok) commit_pend_reg <= 1'b1;
                        else                                   err_pend_reg    <= 1'b1;
                    end else if (sample_edge && !cs_sync) begin
                        // Both bit orders leave the frame as {addr, data}
                        if (MSB_FIRST != 0) shift_reg <= {shift_reg[FRAME_W-2:0], mosi_sync};
                        else                shift_reg <= {mosi_sync, shift_reg[FRAME_W-1:1]};
                        if (bit_cnt_reg != CNT_OVER) bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end
                WAIT_CS: begin
                    if (cs_sync) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            frame_ch_reg    <= '0;
        end else begin
            frame_valid_reg <= commit_pend_reg;
            frame_err_reg   <= err_pend_reg;
            if (commit_pend_reg) frame_ch_reg <= addr;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [D_W-1:0] shadow_reg, active_reg;
        logic           wr;

        assign wr = commit_pend_reg && (addr == CH_W'(gi));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_reg <= '0;
                active_reg <= '0;
            end else begin
                if (wr) shadow_reg <= data;
                if (AUTO_LOAD != 0) begin
                    if (wr) active_reg <= data;
                end else if (ldac) begin
                    // A commit landing with ldac is forwarded straight through
                    active_reg <= wr ? data : shadow_reg;
                end
            end
        end

        assign dac_data[gi*D_W +: D_W] = active_reg;
    end

    assign frame_valid = frame_valid_reg;
    assign frame_err   = frame_err_reg;
    assign frame_ch    = frame_ch_reg;
    assign busy        = busy_reg;

endmodule
